// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 64;
   localparam int CNT_W = $clog2(DIV_WIDTH) + 1;
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider64_sub_wide.sv
// Wide ripple subtractor (A + ~B + 1) built from the 1-bit full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module sub_wide #(
   parameter int N = 65
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);
   logic [N:0] carry;

   assign carry[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         full_adder u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .s   (diff[i]),
            .cout(carry[i+1])
         );
      end
   endgenerate

   // No carry out of A + ~B + 1 means B was larger than A.
   assign borrow = ~carry[N];
endmodule

// File: rtl/seq_divider64.sv
// Multi-cycle unsigned divider: restoring shift-subtract, one quotient bit per cycle.
module seq_divider64
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH) + 1;

   // Handshake: start is taken on an edge where ready=1; done pulses for one
   // cycle when results are valid, and results hold until the next accept.
   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] wquo;
   logic [WIDTH-1:0] dvsr;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             last_iter;
   logic             unused_trial_msb;

   assign shifted = {prem, wquo[WIDTH-1]};

   sub_wide #(.N(WIDTH + 1)) u_sub (
      .a     (shifted),
      .b     ({1'b0, dvsr}),
      .diff  (trial),
      .borrow(borrow)
   );

   // A successful trial is always below the divisor, so its top bit is zero.
   assign unused_trial_msb = trial[WIDTH];
   assign rem_next  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_next  = {wquo[WIDTH-2:0], ~borrow};
   assign last_iter = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         prem        <= '0;
         wquo        <= '0;
         dvsr        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dvsr <= divisor;
                  wquo <= dividend;
                  prem <= '0;
                  cnt  <= '0;
                  if (divisor == '0) begin
                     quotient    <= {WIDTH{1'b1}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               prem <= rem_next;
               wquo <= quo_next;
               cnt  <= cnt + 1'b1;
               if (last_iter) begin
                  quotient    <= quo_next;
                  remainder   <= rem_next;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == RUN) || (state == DONE);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_divider64.sv
// Scoreboard bench for seq_divider64: driver pushes expected results, monitor pops on done.
module tb_seq_divider64;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic [1:0]   state_dbg;

   seq_divider64 #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .state_dbg  (state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_r[$];
   logic         exp_z[$];
   int           exp_t[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference model: plain integer division
   task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b, input int t0);
      if (b == '0) begin
         exp_q.push_back({W{1'b1}});
         exp_r.push_back(a);
         exp_z.push_back(1'b1);
         exp_t.push_back(t0);
      end else begin
         exp_q.push_back(a / b);
         exp_r.push_back(a % b);
         exp_z.push_back(1'b0);
         exp_t.push_back(t0 + W);
      end
   endtask

   // driver
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      int c0;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c0 = cyc;
      push_expected(a, b, c0);
      check("ready_low_after_accept", {63'b0, ready}, 64'd0);
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=%0d pending required=0", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // monitor / scoreboard
   initial begin
      logic [W-1:0] q, r;
      logic         z;
      int           t;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               q = exp_q.pop_front();
               r = exp_r.pop_front();
               z = exp_z.pop_front();
               t = exp_t.pop_front();
               check("quotient", quotient, q);
               check("remainder", remainder, r);
               check("div_by_zero", {63'b0, div_by_zero}, {63'b0, z});
               check("done_cycle", W'(cyc), W'(t));
               check("busy_in_done", {63'b0, busy}, 64'd1);
               @(negedge clk);
               check("done_one_cycle", {63'b0, done}, 64'd0);
               check("ready_after_done", {63'b0, ready}, 64'd1);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", {63'b0, ready}, 64'd1);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_quotient", quotient, 64'd0);
      check("rst_remainder", remainder, 64'd0);
      check("rst_dbz", {63'b0, div_by_zero}, 64'd0);

      // directed cases
      issue(64'd100, 64'd7);
      wait_drain();
      check("q_100_7", quotient, 64'd14);
      issue({W{1'b1}}, 64'd1);
      wait_drain();
      issue(64'd5, 64'd10);
      wait_drain();
      issue(64'h8000_0000_0000_0000, 64'd3);
      wait_drain();
      check("q_2p63_3", quotient, 64'h2AAA_AAAA_AAAA_AAAA);
      issue(64'd42, 64'd0);
      wait_drain();
      check("div0_rem", remainder, 64'd42);
      issue(64'd9, 64'd3);
      wait_drain();

      // start while busy and in DONE is ignored
      issue(64'd100, 64'd7);
      repeat (9) @(negedge clk);
      check("hold_quotient_mid_run", quotient, 64'd3);
      check("busy_mid_run", {63'b0, busy}, 64'd1);
      dividend = 64'd50;
      divisor  = 64'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      start    = 1'b1;
      dividend = 64'd50;
      divisor  = 64'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("start_in_done_ignored", {63'b0, busy}, 64'd0);
      check("ignored_q", quotient, 64'd14);
      check("ignored_r", remainder, 64'd2);

      // reset mid-run discards the operation
      issue(64'd100, 64'd7);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_r.delete();
      exp_z.delete();
      exp_t.delete();
      @(negedge clk);
      check("midrst_ready", {63'b0, ready}, 64'd1);
      check("midrst_busy", {63'b0, busy}, 64'd0);
      check("midrst_quotient", quotient, 64'd0);
      check("midrst_remainder", remainder, 64'd0);
      repeat (80) @(negedge clk);
      issue(64'd100, 64'd7);
      wait_drain();

      // randomized operands, including small and zero divisors
      for (int i = 0; i < 40; i++) begin
         a = {$urandom, $urandom} >> $urandom_range(0, 63);
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 9) == 0) b = '0;
         issue(a, b);
      end
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
